// File: rtl/input_port_buffer.sv
// Receive-side router input buffer: a first-word-fall-through FIFO that stores each
// flit together with its precomputed one-hot XY route label.
module input_port_buffer #(
   parameter int DATASIZE  = 30,
   parameter int DEPTH     = 4,
   parameter int WIDTH     = 2,
   parameter int COORD_W   = 2,
   parameter int router_ID = 6
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [DATASIZE-1:0] data_in,
   input  logic                valid_in,
   output logic                full,
   output logic [DATASIZE-1:0] data_out,
   output logic [4:0]          label,
   input  logic                ready,
   output logic                empty,
   output logic [WIDTH:0]      count,
   output logic                ovf_err
);

   // Label bit order is {W,N,E,S,L}
   localparam logic [4:0] LBL_W = 5'b10000;
   localparam logic [4:0] LBL_N = 5'b01000;
   localparam logic [4:0] LBL_E = 5'b00100;
   localparam logic [4:0] LBL_S = 5'b00010;
   localparam logic [4:0] LBL_L = 5'b00001;

   localparam logic [2*COORD_W-1:0] CUR_ID     = (2*COORD_W)'(router_ID);
   localparam logic [COORD_W-1:0]   CUR_X      = CUR_ID[COORD_W-1:0];
   localparam logic [COORD_W-1:0]   CUR_Y      = CUR_ID[2*COORD_W-1:COORD_W];
   localparam logic [WIDTH:0]       COUNT_FULL = (WIDTH+1)'(DEPTH);
   localparam logic [WIDTH:0]       COUNT_ONE  = (WIDTH+1)'(1);
   localparam logic [WIDTH-1:0]     PTR_ONE    = WIDTH'(1);

   logic [DATASIZE-1:0] data_mem  [DEPTH];
   logic [4:0]          label_mem [DEPTH];

   logic [WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [WIDTH:0]   count_q, count_d;
   logic             ovf_q, ovf_d;

   logic                 push;
   logic                 pop;
   logic [2*COORD_W-1:0] dst;
   logic [COORD_W-1:0]   dst_x;
   logic [COORD_W-1:0]   dst_y;
   logic [4:0]           route_label;

   assign full  = (count_q == COUNT_FULL);
   assign empty = (count_q == '0);
   assign count   = count_q;
   assign ovf_err = ovf_q;

   // Both qualifiers come from the registered count only, so a pop on a full
   // buffer never frees room for a same-cycle push.
   assign push = valid_in & ~full;
   assign pop  = ready & ~empty;

   assign dst   = data_in[DATASIZE-1 -: 2*COORD_W];
   assign dst_x = dst[COORD_W-1:0];
   assign dst_y = dst[2*COORD_W-1:COORD_W];

   // X is resolved before Y; a matching X and Y delivers locally.
   always_comb begin
      route_label = LBL_L;
      if (dst_x > CUR_X) begin
         route_label = LBL_E;
      end else if (dst_x < CUR_X) begin
         route_label = LBL_W;
      end else if (dst_y < CUR_Y) begin
         route_label = LBL_N;
      end else if (dst_y > CUR_Y) begin
         route_label = LBL_S;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + COUNT_ONE;
         2'b01:   count_d = count_q - COUNT_ONE;
         default: count_d = count_q;
      endcase
      if (valid_in && full) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage carries no reset: stale entries are masked by the empty gating below.
   always_ff @(posedge clk) begin
      if (push) begin
         data_mem[wr_ptr_q]  <= data_in;
         label_mem[wr_ptr_q] <= route_label;
      end
   end

   assign data_out = empty ? '0 : data_mem[rd_ptr_q];
   assign label    = empty ? '0 : label_mem[rd_ptr_q];

endmodule

// File: tb/tb_input_port_buffer.sv
// Scoreboard bench for input_port_buffer: stimulus queues expected flit/label pairs,
// a negedge monitor checks each head flit as it is popped.
module tb_input_port_buffer;

   localparam int DATASIZE = 30;
   localparam int WIDTH    = 2;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [DATASIZE-1:0] data_in;
   logic                valid_in;
   logic                full;
   logic [DATASIZE-1:0] data_out;
   logic [4:0]          label;
   logic                ready;
   logic                empty;
   logic [WIDTH:0]      count;
   logic                ovf_err;

   input_port_buffer #(
      .DATASIZE(30), .DEPTH(4), .WIDTH(2), .COORD_W(2), .router_ID(6)
   ) dut (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid_in(valid_in),
      .full(full), .data_out(data_out), .label(label), .ready(ready),
      .empty(empty), .count(count), .ovf_err(ovf_err)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   logic [DATASIZE+4:0] sb[$];

   localparam logic [4:0] W = 5'b10000;
   localparam logic [4:0] N = 5'b01000;
   localparam logic [4:0] E = 5'b00100;
   localparam logic [4:0] S = 5'b00010;
   localparam logic [4:0] L = 5'b00001;

   function automatic logic [DATASIZE-1:0] mk(input logic [3:0] dst, input int payload);
      return {dst, 26'(payload)};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: a pop happens at the coming edge whenever ready is high and the buffer is not empty.
   always @(negedge clk) begin
      if (rst_n && ready && !empty) begin
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL pop_unexpected: got data=%0h label=%b expected nothing", data_out, label);
         end else begin
            logic [DATASIZE+4:0] exp;
            exp = sb.pop_front();
            if (data_out !== exp[DATASIZE+4:5] || label !== exp[4:0]) begin
               miscompares++;
               $display("FAIL pop_head: got data=%0h label=%b expected data=%0h label=%b",
                        data_out, label, exp[DATASIZE+4:5], exp[4:0]);
            end else begin
               $display("pop data=%0h label=%b ok", data_out, label);
            end
         end
      end
   end

   // One clock: drive inputs, record an expected entry if the push will be accepted, step past the edge.
   task automatic cycle(input logic v, input logic [DATASIZE-1:0] d, input logic r, input logic [4:0] lbl);
      valid_in = v;
      data_in  = d;
      ready    = r;
      if (v && !full) sb.push_back({d, lbl});
      @(posedge clk);
      #1;
   endtask

   logic [3:0]  route_dst [6] = '{4'd7, 4'd4, 4'd2, 4'd14, 4'd6, 4'd13};
   logic [4:0]  route_lbl [6] = '{E, W, N, S, L, W};
   logic [3:0]  fill_dst  [4] = '{4'd7, 4'd4, 4'd2, 4'd6};
   logic [4:0]  fill_lbl  [4] = '{E, W, N, L};

   initial begin
      rst_n    = 1'b0;
      valid_in = 1'b0;
      ready    = 1'b0;
      data_in  = '0;
      #1;
      check("reset_count", 32'(count), 32'd0);
      check("reset_empty", 32'(empty), 32'd1);
      check("reset_full", 32'(full), 32'd0);
      check("reset_label", 32'(label), 32'd0);
      check("reset_data", 32'(data_out), 32'd0);
      check("reset_ovf", 32'(ovf_err), 32'd0);
      @(posedge clk); #3;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Route labels, streamed with ready held high
      for (int i = 0; i < 6; i++) cycle(1'b1, mk(route_dst[i], 100 + i), 1'b1, route_lbl[i]);
      cycle(1'b0, '0, 1'b1, 5'b0);
      cycle(1'b0, '0, 1'b1, 5'b0);
      check("route_drained_empty", 32'(empty), 32'd1);

      // Fill to full, then overflow
      for (int i = 0; i < 4; i++) cycle(1'b1, mk(fill_dst[i], 200 + i), 1'b0, fill_lbl[i]);
      check("fill_count", 32'(count), 32'd4);
      check("fill_full", 32'(full), 32'd1);
      check("fill_ovf_clear", 32'(ovf_err), 32'd0);
      cycle(1'b1, mk(4'd14, 999), 1'b0, S);
      check("ovf_set", 32'(ovf_err), 32'd1);
      check("ovf_count", 32'(count), 32'd4);
      check("ovf_head_data", 32'(data_out), 32'(mk(4'd7, 200)));
      check("ovf_head_label", 32'(label), 32'(E));

      // Push while full is rejected even with a same-cycle pop
      cycle(1'b1, mk(4'd13, 998), 1'b1, W);
      check("full_push_pop_count", 32'(count), 32'd3);
      for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 5'b0);
      check("drain_empty", 32'(empty), 32'd1);
      check("drain_label", 32'(label), 32'd0);
      check("drain_data", 32'(data_out), 32'd0);
      check("drain_count", 32'(count), 32'd0);
      check("ovf_sticky", 32'(ovf_err), 32'd1);

      // Simultaneous push/pop at count 2, pointers wrap
      cycle(1'b1, mk(4'd7, 300), 1'b0, E);
      cycle(1'b1, mk(4'd4, 301), 1'b0, W);
      check("simul_pre_count", 32'(count), 32'd2);
      cycle(1'b1, mk(4'd2, 302), 1'b1, N);
      check("simul_count_0", 32'(count), 32'd2);
      cycle(1'b1, mk(4'd14, 303), 1'b1, S);
      check("simul_count_1", 32'(count), 32'd2);
      cycle(1'b1, mk(4'd6, 304), 1'b1, L);
      check("simul_count_2", 32'(count), 32'd2);
      cycle(1'b0, '0, 1'b1, 5'b0);
      cycle(1'b0, '0, 1'b1, 5'b0);
      check("simul_drained", 32'(empty), 32'd1);

      // Ready while empty is ignored; single push falls through next cycle
      cycle(1'b0, '0, 1'b1, 5'b0);
      check("empty_pop_count", 32'(count), 32'd0);
      check("empty_pop_label", 32'(label), 32'd0);
      cycle(1'b1, mk(4'd14, 400), 1'b0, S);
      check("fwft_empty", 32'(empty), 32'd0);
      check("fwft_label", 32'(label), 32'(S));
      check("fwft_data", 32'(data_out), 32'(mk(4'd14, 400)));
      cycle(1'b0, '0, 1'b1, 5'b0);
      check("fwft_popped", 32'(count), 32'd0);

      // Asynchronous reset mid-stream
      for (int i = 0; i < 3; i++) cycle(1'b1, mk(fill_dst[i], 500 + i), 1'b0, fill_lbl[i]);
      cycle(1'b1, mk(4'd7, 503), 1'b0, E);
      cycle(1'b1, mk(4'd7, 504), 1'b0, E);
      check("pre_reset_count", 32'(count), 32'd4);
      check("pre_reset_ovf", 32'(ovf_err), 32'd1);
      valid_in = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      sb.delete();
      check("async_count", 32'(count), 32'd0);
      check("async_empty", 32'(empty), 32'd1);
      check("async_full", 32'(full), 32'd0);
      check("async_label", 32'(label), 32'd0);
      check("async_data", 32'(data_out), 32'd0);
      check("async_ovf", 32'(ovf_err), 32'd0);
      @(posedge clk); #3;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Buffer usable after reset
      cycle(1'b1, mk(4'd13, 600), 1'b0, W);
      cycle(1'b0, '0, 1'b1, 5'b0);
      cycle(1'b0, '0, 1'b0, 5'b0);
      check("post_reset_empty", 32'(empty), 32'd1);
      check("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
